mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that sits on the processor's data-memory bus next to `dmem` and acts as a responder to processor loads and stores. Stores to its transmit register push bytes into a small FIFO. An 8N1 serializer drains the FIFO onto a single `tx` line. Loads return FIFO and transmitter status, so firmware can poll before it writes.

---
 rtl/mmio_uart_tx_pkg.sv | 18 +
 rtl/mmio_uart_tx_sync_fifo.sv | 58 +++++
 rtl/mmio_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and serializer state encodings.
package mmio_defs;
    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;
endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy counter; a push on a full FIFO is taken
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a FIFO that a
// serializer drains onto tx; STATUS reports FIFO/serializer state.
module mmio_uart_tx
    import mmio_defs::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic        hit,
    output logic [31:0] rd,
    output logic        tx
);
    localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic        sel_tx;
    logic        sel_st;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [7:0]  dout;
    logic        overflow;
    logic        busy;
    logic        unused_wd;

    tx_state_e         state, state_n;
    logic [2:0]        bit_cnt, bit_n;
    logic [BAUD_W-1:0] baud_cnt, baud_n;
    logic [7:0]        shreg, shreg_n;
    logic              tx_n;
    logic              baud_last;

    assign sel_tx    = (addr == BASE_ADDR + TXDATA_OFS);
    assign sel_st    = (addr == BASE_ADDR + STATUS_OFS);
    assign hit       = sel_tx || sel_st;
    assign push      = we && sel_tx;
    assign busy      = (state != S_IDLE);
    assign unused_wd = ^wd[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (wd[7:0]),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        rd = '0;
        if (sel_st) begin
            rd[ST_FULL]  = full;
            rd[ST_EMPTY] = empty;
            rd[ST_BUSY]  = busy;
            rd[ST_OVF]   = overflow;
        end
    end

    // A dropped byte sets the flag; set is checked last so it wins over clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else begin
            if (we && sel_st && wd[ST_OVF]) begin
                overflow <= 1'b0;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_n;
            baud_cnt <= baud_n;
            tx       <= tx_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

    assign baud_last = (baud_cnt == BAUD_LAST);

    // tx is registered from the next-state view so it changes on the same
    // edge the state does.
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        baud_n  = baud_cnt;
        shreg_n = shreg;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = dout;
                    bit_n   = '0;
                    baud_n  = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = S_DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_n   = '0;
                        state_n = S_STOP;
                    end else begin
                        bit_n   = bit_cnt + 3'd1;
                        shreg_n = {1'b0, shreg[7:1]};
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_n = dout;
                        bit_n   = '0;
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam int          CPB   = 16;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wd    = 32'h0;
    logic        hit;
    logic [31:0] rd;
    logic        tx;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .addr  (addr),
        .wd    (wd),
        .hit   (hit),
        .rd    (rd),
        .tx    (tx)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: byte queue plus a frame position counter.
    logic [7:0] mq[$];
    bit         m_busy = 0;
    int         m_pos  = 0;
    logic [7:0] m_byte = 8'h0;
    bit         m_ovf  = 0;
    bit         m_live = 0;
    bit         m_pop;
    logic [7:0] m_nb;

    function automatic logic m_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_pos / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    function automatic logic [31:0] m_status();
        return {28'b0, m_ovf, m_busy, mq.size() == 0, mq.size() == DEPTH};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_busy = 0;
            m_pos  = 0;
            m_ovf  = 0;
            m_live = 1;
        end else begin
            m_pop = (!m_busy || m_pos == FRAME - 1) && mq.size() > 0;
            m_nb  = 8'h0;
            if (m_pop) m_nb = mq.pop_front();
            if (we && addr == BASE + 32'd4 && wd[3]) m_ovf = 0;
            if (we && addr == BASE) begin
                if (mq.size() < DEPTH) mq.push_back(wd[7:0]);
                else m_ovf = 1;
            end
            if (m_busy && m_pos < FRAME - 1) begin
                m_pos++;
            end else if (m_pop) begin
                m_busy = 1;
                m_pos  = 0;
                m_byte = m_nb;
            end else begin
                m_busy = 0;
                m_pos  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("tx", {31'b0, tx}, {31'b0, m_tx()});
            check("hit", {31'b0, hit}, {31'b0, (addr == BASE || addr == BASE + 32'd4)});
            check("rd", rd, (addr == BASE + 32'd4) ? m_status() : 32'h0);
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        we   = 1'b1;
        addr = a;
        wd   = d;
    endtask

    task automatic bus_idle_status();
        @(posedge clk);
        #1;
        we   = 1'b0;
        addr = BASE + 32'd4;
        wd   = 32'h0;
    endtask

    int ones;
    int busy_cnt;
    int falls;
    int bad;
    bit prev_busy;
    bit found;
    logic [9:0] pat55;

    initial begin
        // Reset held two cycles
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        addr = BASE + 32'd4;
        @(negedge clk);
        check("reset_status", rd, 32'h2);
        ones = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx) ones++;
        end
        check("idle_tx_high", ones, 100);

        // Single byte 0x55: start,1,0,1,0,1,0,1,0,stop
        pat55 = 10'b10_1010_1010;
        bus_write(BASE, 32'h0000_0155);
        bus_idle_status();
        @(negedge clk);
        check("tx_before_pop", {31'b0, tx}, 32'h1);
        bad = 0;
        busy_cnt = 0;
        for (int i = 0; i < FRAME + 10; i++) begin
            @(negedge clk);
            if (i < FRAME && tx !== pat55[i / CPB]) bad++;
            if (i == 0) check("start_bit", {31'b0, tx}, 32'h0);
            if (rd[2]) busy_cnt++;
        end
        check("frame_55_bits", bad, 0);
        check("busy_160", busy_cnt, 160);

        // Back-to-back frames
        bus_write(BASE, 32'h0000_00A5);
        bus_write(BASE, 32'h0000_003C);
        bus_idle_status();
        busy_cnt = 0;
        falls = 0;
        prev_busy = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rd[2]) busy_cnt++;
            if (prev_busy && !rd[2]) falls++;
            prev_busy = rd[2];
        end
        check("b2b_busy_320", busy_cnt, 320);
        check("b2b_contiguous", falls, 1);
        check("b2b_status", rd, 32'h2);

        // Overflow: six consecutive writes, the sixth is dropped
        for (int i = 0; i < 6; i++) bus_write(BASE, 32'h10 + i);
        bus_idle_status();
        @(negedge clk);
        check("ovf_status", rd, 32'hD);
        bus_write(BASE + 32'd4, 32'h8);
        bus_idle_status();
        @(negedge clk);
        check("ovf_cleared", rd, 32'h5);

        // Decode: BASE+8 is not ours
        bus_write(BASE + 32'd8, 32'h77);
        @(negedge clk);
        check("decode_hit", {31'b0, hit}, 32'h0);
        check("decode_rd", rd, 32'h0);
        bus_idle_status();
        @(negedge clk);
        check("decode_no_push", rd, 32'h5);

        // Reset during data bit 4 of the frame in flight
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (m_busy && m_pos / CPB == 5) found = 1;
        end
        check("reach_data_bit4", {31'b0, found}, 32'h1);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_mid_tx", {31'b0, tx}, 32'h1);
        check("reset_mid_status", rd, 32'h2);
        ones = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx) ones++;
        end
        check("no_frames_after_reset", ones, 200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
